// File: rtl/xmodem_loader.sv
// XMODEM (8-bit checksum) receiver that streams 128-byte blocks into instruction memory.
// Define XMODEM_LOADER_TIMEOUT_EN to add the inactivity timeout (NAK + rewind after TIMEOUT_CYCLES idle cycles).
module xmodem_loader #(
    parameter int NB_UART_DATA    = 8,
    parameter int NB_INSTRUCTION  = 32,
    parameter int IMEM_ADDR_WIDTH = 7,
    parameter int TIMEOUT_CYCLES  = 10000000
) (
    input  logic                       clk,
    input  logic                       i_rst,
    input  logic                       i_en,
    input  logic [NB_UART_DATA-1:0]    i_uart_rx_data,
    input  logic                       i_uart_rx_done,
    output logic                       o_uart_rd,
    input  logic                       i_uart_tx_done,
    output logic                       o_uart_wr,
    output logic [NB_UART_DATA-1:0]    o_uart_wdata,
    output logic                       o_uart_tx_start,
    output logic                       o_imem_wr,
    output logic [IMEM_ADDR_WIDTH-1:0] o_imem_addr,
    output logic [NB_INSTRUCTION-1:0]  o_imem_data,
    output logic                       o_busy,
    output logic                       o_done
);

    localparam int BPW     = NB_INSTRUCTION / NB_UART_DATA;
    localparam int LOG_BPW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [NB_UART_DATA-1:0]    SOH    = NB_UART_DATA'(8'h01);
    localparam logic [NB_UART_DATA-1:0]    EOT    = NB_UART_DATA'(8'h04);
    localparam logic [NB_UART_DATA-1:0]    ACK    = NB_UART_DATA'(8'h06);
    localparam logic [NB_UART_DATA-1:0]    NAK    = NB_UART_DATA'(8'h15);
    localparam logic [NB_UART_DATA-1:0]    ONE_B  = NB_UART_DATA'(1'b1);
    localparam logic [IMEM_ADDR_WIDTH-1:0] ONE_A  = IMEM_ADDR_WIDTH'(1'b1);

    if (BPW < 2 || (NB_INSTRUCTION % NB_UART_DATA) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("xmodem_loader: unsupported parameter combination");
    end

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_BLK      = 4'd1,
        ST_BLK_N    = 4'd2,
        ST_DATA     = 4'd3,
        ST_CKSUM    = 4'd4,
        ST_TX_WR    = 4'd5,
        ST_TX_START = 4'd6,
        ST_TX_WAIT  = 4'd7,
        ST_DONE     = 4'd8
    } state_t;

    function automatic logic [NB_UART_DATA-1:0] cksum_add(input logic [NB_UART_DATA-1:0] sum,
                                                           input logic [NB_UART_DATA-1:0] data);
        return sum + data;
    endfunction

    state_t                       state_q, state_d;
    logic [NB_UART_DATA-1:0]      exp_q, exp_d, blk_q, blk_d, cks_q, cks_d, wdata_q, wdata_d;
    logic                         bad_q, bad_d, eot_q, eot_d, busy_q, busy_d, done_q, done_d;
    logic                         rd_q, rd_d, gap_q, gap_d, wr_q, wr_d, start_q, start_d;
    logic                         imem_wr_q, imem_wr_d;
    logic [7:0]                   cnt_q, cnt_d;
    logic [NB_INSTRUCTION-1:0]    word_q, word_d, imem_data_q, imem_data_d;
    logic [IMEM_ADDR_WIDTH-1:0]   addr_q, addr_d, base_q, base_d, prev_q, prev_d;
    logic [IMEM_ADDR_WIDTH-1:0]   imem_addr_q, imem_addr_d;
    logic                         take_s, cks_ok_s;
`ifdef XMODEM_LOADER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TMO_W-1:0]             tmo_q, tmo_d;
    logic                         tmo_arm_s;
`endif

    // A byte is accepted only in receive states and outside the pop/gap cycles of the previous byte.
    always_comb begin
        take_s = 1'b0;
        case (state_q)
            ST_IDLE, ST_BLK, ST_BLK_N, ST_DATA, ST_CKSUM:
                take_s = i_en & i_uart_rx_done & ~rd_q & ~gap_q;
            default: take_s = 1'b0;
        endcase
    end

    // Next-state, datapath and strobe computation; i_en low holds everything.
    always_comb begin
        state_d = state_q;  exp_d = exp_q;  blk_d = blk_q;  cks_d = cks_q;  wdata_d = wdata_q;
        bad_d = bad_q;  eot_d = eot_q;  busy_d = busy_q;  done_d = done_q;  cnt_d = cnt_q;
        rd_d = rd_q;  gap_d = gap_q;  wr_d = wr_q;  start_d = start_q;  imem_wr_d = imem_wr_q;
        word_d = word_q;  imem_data_d = imem_data_q;  imem_addr_d = imem_addr_q;
        addr_d = addr_q;  base_d = base_q;  prev_d = prev_q;
        cks_ok_s = (i_uart_rx_data == cks_q);
`ifdef XMODEM_LOADER_TIMEOUT_EN
        tmo_d = tmo_q;
        tmo_arm_s = 1'b0;
`endif
        if (i_en) begin
            rd_d = take_s;
            gap_d = rd_q;
            wr_d = 1'b0;
            start_d = 1'b0;
            imem_wr_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (take_s && i_uart_rx_data == SOH) begin
                        state_d = ST_BLK;
                        cks_d = '0;
                        cnt_d = 8'd0;
                        bad_d = 1'b0;
                        busy_d = 1'b1;
                    end else if (take_s && i_uart_rx_data == EOT) begin
                        state_d = ST_TX_WR;
                        wr_d = 1'b1;
                        wdata_d = ACK;
                        eot_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_BLK: begin
                    if (take_s) begin
                        // A repeat of the last accepted block overwrites that block's own words.
                        blk_d = i_uart_rx_data;
                        addr_d = (i_uart_rx_data == exp_q - ONE_B) ? prev_q : base_q;
                        state_d = ST_BLK_N;
                    end else begin
                        state_d = ST_BLK;
                    end
                end
                ST_BLK_N: begin
                    if (take_s) begin
                        bad_d = (i_uart_rx_data != ~blk_q);
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_BLK_N;
                    end
                end
                ST_DATA: begin
                    if (take_s) begin
                        cks_d = cksum_add(cks_q, i_uart_rx_data);
                        word_d = {i_uart_rx_data, word_q[NB_INSTRUCTION-1:NB_UART_DATA]};
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_q[LOG_BPW-1:0] == LOG_BPW'(BPW - 1)) begin
                            imem_wr_d = 1'b1;
                            imem_addr_d = addr_q;
                            imem_data_d = {i_uart_rx_data, word_q[NB_INSTRUCTION-1:NB_UART_DATA]};
                            addr_d = addr_q + ONE_A;
                        end else begin
                            imem_wr_d = 1'b0;
                        end
                        state_d = (cnt_q == 8'd127) ? ST_CKSUM : ST_DATA;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_CKSUM: begin
                    if (take_s) begin
                        state_d = ST_TX_WR;
                        wr_d = 1'b1;
                        if (cks_ok_s && !bad_q && blk_q == exp_q) begin
                            wdata_d = ACK;
                            exp_d = exp_q + ONE_B;
                            prev_d = base_q;
                            base_d = addr_q;
                        end else if (cks_ok_s && !bad_q && blk_q == exp_q - ONE_B) begin
                            wdata_d = ACK;
                            addr_d = base_q;
                        end else begin
                            wdata_d = NAK;
                            addr_d = base_q;
                        end
                    end else begin
                        state_d = ST_CKSUM;
                    end
                end
                ST_TX_WR: begin
                    state_d = ST_TX_START;
                    start_d = 1'b1;
                end
                ST_TX_START: state_d = ST_TX_WAIT;
                ST_TX_WAIT: begin
                    if (i_uart_tx_done && eot_q) begin
                        state_d = ST_DONE;
                        done_d = 1'b1;
                        busy_d = 1'b0;
                    end else if (i_uart_tx_done) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_TX_WAIT;
                    end
                end
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
`ifdef XMODEM_LOADER_TIMEOUT_EN
            case (state_q)
                ST_BLK, ST_BLK_N, ST_DATA, ST_CKSUM: tmo_arm_s = 1'b1;
                ST_IDLE:                             tmo_arm_s = busy_q;
                default:                             tmo_arm_s = 1'b0;
            endcase
            if (!tmo_arm_s || take_s) begin
                tmo_d = '0;
            end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                tmo_d = '0;
                state_d = ST_TX_WR;
                wr_d = 1'b1;
                wdata_d = NAK;
                addr_d = base_q;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
`endif
        end else begin
            state_d = state_q;
        end
    end

    // State and registered outputs; reset abandons any block or reply in progress.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;  exp_q <= ONE_B;  blk_q <= '0;  cks_q <= '0;  wdata_q <= '0;
            bad_q <= 1'b0;  eot_q <= 1'b0;  busy_q <= 1'b0;  done_q <= 1'b0;  cnt_q <= 8'd0;
            rd_q <= 1'b0;  gap_q <= 1'b0;  wr_q <= 1'b0;  start_q <= 1'b0;  imem_wr_q <= 1'b0;
            word_q <= '0;  imem_data_q <= '0;  imem_addr_q <= '0;
            addr_q <= '0;  base_q <= '0;  prev_q <= '0;
`ifdef XMODEM_LOADER_TIMEOUT_EN
            tmo_q <= '0;
`endif
        end else begin
            state_q <= state_d;  exp_q <= exp_d;  blk_q <= blk_d;  cks_q <= cks_d;  wdata_q <= wdata_d;
            bad_q <= bad_d;  eot_q <= eot_d;  busy_q <= busy_d;  done_q <= done_d;  cnt_q <= cnt_d;
            rd_q <= rd_d;  gap_q <= gap_d;  wr_q <= wr_d;  start_q <= start_d;  imem_wr_q <= imem_wr_d;
            word_q <= word_d;  imem_data_q <= imem_data_d;  imem_addr_q <= imem_addr_d;
            addr_q <= addr_d;  base_q <= base_d;  prev_q <= prev_d;
`ifdef XMODEM_LOADER_TIMEOUT_EN
            tmo_q <= tmo_d;
`endif
        end
    end

    assign o_uart_rd       = rd_q & i_en;
    assign o_uart_wr       = wr_q & i_en;
    assign o_uart_tx_start = start_q & i_en;
    assign o_imem_wr       = imem_wr_q & i_en;
    assign o_uart_wdata    = wdata_q;
    assign o_imem_addr     = imem_addr_q;
    assign o_imem_data     = imem_data_q;
    assign o_busy          = busy_q;
    assign o_done          = done_q;

endmodule
